wb_arbiter: RTL and testbench

Parametrised writeback collector between the functional units and the common writeback/wakeup broadcast. It accepts writeback packets (al_idx, data, rd, uses_rd) from NUM_IN producer channels, each with its own FIFO and valid/ready backpressure. Each cycle it grants up to NUM_OUT packets round-robin onto NUM_OUT broadcast ports feeding the register file, the IQ wakeup logic and active-list completion. A global flush drops all buffered writebacks on a pipeline redirect or exception.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/wb_fifo.sv | 77 +++++++
 rtl/wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared backend types and sizing constants.
// Holds the writeback packet broadcast to RF, IQ wakeup and active list.
`ifndef NUM_PR
`define NUM_PR 64
`endif
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_PR   = `NUM_PR;
    localparam int AL_SIZE  = `AL_SIZE;
    localparam int PR_IDX_W = $clog2(NUM_PR);
    localparam int AL_IDX_W = $clog2(AL_SIZE);

    typedef struct packed {
        logic [AL_IDX_W-1:0] al_idx;
        logic [XLEN-1:0]     data;
        logic [PR_IDX_W-1:0] rd;
        logic                uses_rd;
    } WbPacket;

    // Index increment that wraps at n (n need not be a power of 2).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: one producer channel FIFO for the writeback collector.
// Registered count drives full/empty; flush empties it synchronously.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = WbPacket
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       flush,
    input  logic                       push,
    input  T                           pkt_in,
    input  logic                       pop,
    output T                           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= pkt_in;
        end
    end

    // Pointers and occupancy; a full FIFO never accepts, even while popping.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_push_full : assert property (
        @(posedge clk) disable iff (!n_rst) !(push && full));

    a_no_underflow : assert property (
        @(posedge clk) disable iff (!n_rst) !(pop && empty));

    a_count_range : assert property (
        @(posedge clk) disable iff (!n_rst) count <= CW'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: per-channel writeback FIFOs feeding NUM_OUT broadcast ports.
// Round-robin grant from registered state; flush drops everything buffered.
`ifndef NUM_PR
`define NUM_PR 64
`endif
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int NUM_OUT    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int PR_W       = $clog2(`NUM_PR),
    parameter int AL_W       = $clog2(`AL_SIZE)
) (
    input  logic                                      clk,
    input  logic                                      n_rst,
    input  logic                                      flush,
    input  logic [NUM_IN-1:0]                         in_valid,
    output logic [NUM_IN-1:0]                         in_ready,
    input  logic [NUM_IN*AL_W-1:0]                    in_al_idx,
    input  logic [NUM_IN*DATA_W-1:0]                  in_data,
    input  logic [NUM_IN*PR_W-1:0]                    in_rd,
    input  logic [NUM_IN-1:0]                         in_uses_rd,
    output logic [NUM_OUT-1:0]                        out_valid,
    output logic [NUM_OUT*AL_W-1:0]                   out_al_idx,
    output logic [NUM_OUT*DATA_W-1:0]                 out_data,
    output logic [NUM_OUT*PR_W-1:0]                   out_rd,
    output logic [NUM_OUT-1:0]                        out_uses_rd,
    output logic [NUM_IN*$clog2(FIFO_DEPTH+1)-1:0]    occupancy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(NUM_IN);

    typedef struct packed {
        logic [AL_W-1:0]   al_idx;
        logic [DATA_W-1:0] data;
        logic [PR_W-1:0]   rd;
        logic              uses_rd;
    } pkt_t;

    pkt_t              in_pkt   [NUM_IN];
    pkt_t              head     [NUM_IN];
    logic [CW-1:0]     count    [NUM_IN];
    logic [NUM_IN-1:0] empty;
    logic [NUM_IN-1:0] full;
    logic [NUM_IN-1:0] grant;
    logic [NUM_IN-1:0] push;

    pkt_t              port_pkt [NUM_OUT];
    logic [NUM_OUT-1:0] port_valid;

    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     rr_next;

    int                offset   [NUM_IN];
    int                rank     [NUM_IN];
    int                best_off;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        assign in_pkt[i].al_idx  = in_al_idx[i*AL_W +: AL_W];
        assign in_pkt[i].data    = in_data[i*DATA_W +: DATA_W];
        assign in_pkt[i].rd      = in_rd[i*PR_W +: PR_W];
        assign in_pkt[i].uses_rd = in_uses_rd[i];

        assign in_ready[i] = ~full[i];
        assign push[i]     = in_valid[i] & ~full[i];
        assign occupancy[i*CW +: CW] = count[i];

        wb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .T     (pkt_t)
        ) u_fifo (
            .clk    (clk),
            .n_rst  (n_rst),
            .flush  (flush),
            .push   (push[i]),
            .pkt_in (in_pkt[i]),
            .pop    (grant[i]),
            .head   (head[i]),
            .empty  (empty[i]),
            .full   (full[i]),
            .count  (count[i])
        );
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_port
        assign out_valid[k]               = port_valid[k];
        assign out_al_idx[k*AL_W +: AL_W] = port_pkt[k].al_idx;
        assign out_data[k*DATA_W +: DATA_W] = port_pkt[k].data;
        assign out_rd[k*PR_W +: PR_W]     = port_pkt[k].rd;
        assign out_uses_rd[k]             = port_pkt[k].uses_rd;
    end

    // Round-robin picker: rank non-empty channels by distance from rr_ptr,
    // the lowest NUM_OUT ranks win and rank k drives port k.
    always_comb begin
        grant      = '0;
        port_valid = '0;
        rr_next    = rr_ptr;
        best_off   = -1;
        for (int k = 0; k < NUM_OUT; k++) begin
            port_pkt[k] = '0;
        end
        for (int c = 0; c < NUM_IN; c++) begin
            offset[c] = (c + NUM_IN - int'(rr_ptr)) % NUM_IN;
        end
        for (int c = 0; c < NUM_IN; c++) begin
            rank[c] = 0;
            for (int d = 0; d < NUM_IN; d++) begin
                if (!empty[d] && offset[d] < offset[c]) begin
                    rank[c] = rank[c] + 1;
                end
            end
        end
        for (int c = 0; c < NUM_IN; c++) begin
            grant[c] = !flush && !empty[c] && (rank[c] < NUM_OUT);
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            for (int c = 0; c < NUM_IN; c++) begin
                if (grant[c] && rank[c] == k) begin
                    port_valid[k] = 1'b1;
                    port_pkt[k]   = head[c];
                end
            end
        end
        for (int c = 0; c < NUM_IN; c++) begin
            if (grant[c] && offset[c] > best_off) begin
                best_off = offset[c];
                rr_next  = IW'(wrap_inc(c, NUM_IN));
            end
        end
    end

    // Round-robin pointer: resumes after the last granted channel.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rr_ptr <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a queue-based model of the writeback collector.
module tb_wb_arbiter;

    localparam int NI = 4;
    localparam int NO = 2;
    localparam int D  = 4;
    localparam int DW = 32;
    localparam int PW = 6;
    localparam int AW = 5;
    localparam int CW = 3;

    typedef struct packed {
        logic [AW-1:0] al;
        logic [DW-1:0] data;
        logic [PW-1:0] rd;
        logic          uses;
    } tpkt;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             flush;
    logic [NI-1:0]    in_valid;
    logic [NI-1:0]    in_ready;
    logic [NI*AW-1:0] in_al_idx;
    logic [NI*DW-1:0] in_data;
    logic [NI*PW-1:0] in_rd;
    logic [NI-1:0]    in_uses_rd;
    logic [NO-1:0]    out_valid;
    logic [NO*AW-1:0] out_al_idx;
    logic [NO*DW-1:0] out_data;
    logic [NO*PW-1:0] out_rd;
    logic [NO-1:0]    out_uses_rd;
    logic [NI*CW-1:0] occupancy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .NUM_IN     (NI),
        .NUM_OUT    (NO),
        .FIFO_DEPTH (D),
        .DATA_W     (DW),
        .PR_W       (PW),
        .AL_W       (AW)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_al_idx   (in_al_idx),
        .in_data     (in_data),
        .in_rd       (in_rd),
        .in_uses_rd  (in_uses_rd),
        .out_valid   (out_valid),
        .out_al_idx  (out_al_idx),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_uses_rd (out_uses_rd),
        .occupancy   (occupancy)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    tpkt mq [NI][$];
    int  mrr;
    int  msz [NI];
    int  mn;
    int  mlast;
    int  mc;

    function automatic tpkt cur_pkt(input int c);
        tpkt p;
        p.al   = in_al_idx[c*AW +: AW];
        p.data = in_data[c*DW +: DW];
        p.rd   = in_rd[c*PW +: PW];
        p.uses = in_uses_rd[c];
        return p;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst || flush) begin
            for (int i = 0; i < NI; i++) mq[i].delete();
            mrr = 0;
        end else begin
            for (int i = 0; i < NI; i++) msz[i] = mq[i].size();
            mn    = 0;
            mlast = -1;
            for (int j = 0; j < NI; j++) begin
                mc = (mrr + j) % NI;
                if (msz[mc] > 0 && mn < NO) begin
                    void'(mq[mc].pop_front());
                    mn++;
                    mlast = mc;
                end
            end
            for (int i = 0; i < NI; i++) begin
                if (in_valid[i] && msz[i] < D) mq[i].push_back(cur_pkt(i));
            end
            if (mlast >= 0) mrr = (mlast + 1) % NI;
        end
    end

    // ---------------- compare process ----------------
    logic          chk_en = 1'b0;
    logic          sat_phase = 1'b0;
    logic          saw_not_ready = 1'b0;
    int            bcount = 0;
    tpkt           ep [NO];
    logic [NO-1:0] ev;
    logic [NI-1:0] er;
    logic [NI*CW-1:0] eo;
    int            en;
    int            ec;
    tpkt           ap;

    always @(negedge clk) begin
        if (chk_en && n_rst) begin
            ev = '0;
            en = 0;
            for (int k = 0; k < NO; k++) ep[k] = '0;
            if (!flush) begin
                for (int j = 0; j < NI; j++) begin
                    ec = (mrr + j) % NI;
                    if (mq[ec].size() > 0 && en < NO) begin
                        ep[en] = mq[ec][0];
                        ev = ev | (NO'(1) << en);
                        en++;
                    end
                end
            end
            chk("m_out_valid", 64'(out_valid), 64'(ev));
            for (int k = 0; k < NO; k++) begin
                ap.al   = out_al_idx[k*AW +: AW];
                ap.data = out_data[k*DW +: DW];
                ap.rd   = out_rd[k*PW +: PW];
                ap.uses = out_uses_rd[k];
                chk($sformatf("m_port%0d", k), 64'(ap), 64'(ep[k]));
            end
            for (int i = 0; i < NI; i++) begin
                er[i] = (mq[i].size() < D);
                eo[i*CW +: CW] = CW'(mq[i].size());
            end
            chk("m_in_ready", 64'(in_ready), 64'(er));
            chk("m_occupancy", 64'(occupancy), 64'(eo));
            bcount += $countones(out_valid);
            if (sat_phase && in_ready != 4'hF) saw_not_ready = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    int seq = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [AW-1:0] al,
                          input logic [DW-1:0] d, input logic [PW-1:0] rd,
                          input logic u);
        in_valid[c]          = 1'b1;
        in_al_idx[c*AW +: AW] = al;
        in_data[c*DW +: DW]   = d;
        in_rd[c*PW +: PW]     = rd;
        in_uses_rd[c]         = u;
    endtask

    task automatic drive_random(input logic [NI-1:0] mask);
        for (int c = 0; c < NI; c++) begin
            set_ch(c, AW'($urandom), DW'(seq), PW'($urandom),
                   1'($urandom));
            seq++;
        end
        in_valid = mask;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int b0;

    initial begin
        n_rst = 1'b0;
        flush = 1'b0;
        in_valid = '0;
        in_al_idx = '0;
        in_data = '0;
        in_rd = '0;
        in_uses_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'hF);
        chk("rst_occupancy", 64'(occupancy), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        #2 n_rst = 1'b1;
        chk_en = 1'b1;
        tick();

        // single packet on ch2
        set_ch(2, 5'd5, 32'hDEADBEEF, 6'd17, 1'b1);
        tick();
        in_valid = '0;
        @(negedge clk);
        chk("single_valid", 64'(out_valid), 64'h1);
        chk("single_data", 64'(out_data), 64'h00000000DEADBEEF);
        chk("single_al", 64'(out_al_idx), 64'd5);
        chk("single_rd", 64'(out_rd), 64'd17);
        chk("single_uses", 64'(out_uses_rd), 64'h1);
        @(negedge clk);
        chk("single_occ", 64'(occupancy), 64'h0);
        tick();

        // empty flush returns rr to channel 0
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // fairness
        for (int c = 0; c < NI; c++)
            set_ch(c, AW'(c), 32'hF0000000 + DW'(c), PW'(c), 1'b1);
        tick();
        in_valid = '0;
        @(negedge clk);
        chk("fair_v1", 64'(out_valid), 64'h3);
        chk("fair_d1", 64'(out_data), 64'hF0000001F0000000);
        @(negedge clk);
        chk("fair_v2", 64'(out_valid), 64'h3);
        chk("fair_d2", 64'(out_data), 64'hF0000003F0000002);
        tick();
        set_ch(0, 5'd0, 32'hA0, 6'd0, 1'b1);
        set_ch(3, 5'd3, 32'hA3, 6'd3, 1'b1);
        tick();
        in_valid = '0;
        @(negedge clk);
        chk("fair_rr0", 64'(out_data), 64'h000000A3000000A0);
        @(negedge clk);
        tick();

        // non-writing op
        set_ch(3, 5'd7, 32'h12345678, 6'd9, 1'b0);
        tick();
        in_valid = '0;
        @(negedge clk);
        chk("nowr_valid", 64'(out_valid), 64'h1);
        chk("nowr_uses", 64'(out_uses_rd), 64'h0);
        chk("nowr_al", 64'(out_al_idx), 64'd7);
        chk("nowr_rd", 64'(out_rd), 64'd9);
        @(negedge clk);
        tick();

        // flush with 6 buffered and a push on ch1
        for (int c = 0; c < NI; c++)
            set_ch(c, AW'(c), 32'hB0000000 + DW'(c), PW'(c), 1'b1);
        tick();
        for (int c = 0; c < NI; c++)
            set_ch(c, AW'(c), 32'hB1000000 + DW'(c), PW'(c), 1'b1);
        tick();
        in_valid = '0;
        set_ch(1, 5'd1, 32'hBAD00001, 6'd1, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_valid", 64'(out_valid), 64'h0);
        chk("flush_occ_pre", 64'(occupancy), 64'h489);
        chk("flush_ready", 64'(in_ready), 64'hF);
        tick();
        flush = 1'b0;
        in_valid = '0;
        @(negedge clk);
        chk("flush_occ_post", 64'(occupancy), 64'h0);
        chk("flush_valid_post", 64'(out_valid), 64'h0);
        tick();

        // reset mid-traffic with 3 buffered
        set_ch(0, 5'd1, 32'hC0, 6'd1, 1'b1);
        set_ch(1, 5'd2, 32'hC1, 6'd2, 1'b1);
        set_ch(2, 5'd3, 32'hC2, 6'd3, 1'b1);
        tick();
        in_valid = '0;
        @(negedge clk);
        chk("rst_mid_occ_pre", 64'(occupancy), 64'h049);
        #1 n_rst = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'h0);
        chk("rst_mid_ready", 64'(in_ready), 64'hF);
        chk("rst_mid_occ", 64'(occupancy), 64'h0);
        @(negedge clk);
        #2 n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'h0);
        end
        tick();

        // saturation
        sat_phase = 1'b1;
        b0 = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            drive_random(4'hF);
            if (cyc == 4) b0 = bcount;
            tick();
        end
        sat_phase = 1'b0;
        chk("sat_throughput", 64'(bcount - b0), 64'd112);
        chk("sat_backpressure", 64'(saw_not_ready), 64'h1);

        // randomized traffic with occasional flushes
        for (int cyc = 0; cyc < 1500; cyc++) begin
            drive_random(NI'($urandom));
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;
        in_valid = '0;
        repeat (10) tick();
        chk("drain_occ", 64'(occupancy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
